// File: rtl/fifo_stream_reader_if.sv
// Fifo read port plus outgoing valid/ready stream, bundled for the stream reader.
// No logic of its own: a pure signal bundle, zero latency.
// Backpressure travels on m_ready; the Fifo side has no backpressure beyond fifo_empty.
interface fifo_stream_reader_if #(
  parameter int DATA_W = 32
);
  // Fifo read side
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_read;

  // Outgoing stream
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  // The reader: pops the Fifo and sources the stream
  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  m_ready,
    output fifo_read,
    output m_data,
    output m_valid,
    output m_last
  );

  // The surroundings: the Fifo plus the downstream consumer
  modport slave (
    output fifo_empty,
    output fifo_data,
    output m_ready,
    input  fifo_read,
    input  m_data,
    input  m_valid,
    input  m_last
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains `length` words from a registered-output Fifo onto a valid/ready stream.
// Latency: first m_valid 2 cycles after the first fifo_read; then 1 word/cycle.
// Backpressure: m_ready low stalls the head word; a 2-entry skid buffer with credit-gated reads never overflows.
module fifo_stream_reader #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  fifo_stream_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  state_t            state_d;

  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_cnt;
  logic [LEN_W-1:0]  sent_cnt;

  // pending: a read was issued last cycle, its word is on fifo_data now
  logic              pending;
  logic [1:0]        buf_cnt;
  logic [DATA_W-1:0] buf0;   // head entry
  logic [DATA_W-1:0] buf1;

  logic              pop;
  logic              rd;
  logic [1:0]        occ;
  logic              last_beat;
  logic              start_burst;

  // Stream outputs, credit-gated read strobe and the handshake terms
  always_comb begin
    occ         = buf_cnt + {1'b0, pending};
    bus.m_valid = (buf_cnt != 2'd0);
    bus.m_data  = buf0;
    bus.m_last  = bus.m_valid && (sent_cnt == len_q - ONE);
    pop         = bus.m_valid && bus.m_ready;
    last_beat   = pop && (sent_cnt == len_q - ONE);
    start_burst = (state_q == IDLE) && start && (length != '0);
    // A slot freed by this cycle's pop can be re-used by this cycle's read
    rd = (state_q == DRAIN) && !bus.fifo_empty && (issued_cnt != len_q) &&
         (pop ? (occ < 2'd3) : (occ < 2'd2));
    bus.fifo_read = rd;
    busy = (state_q == DRAIN);
    done = (state_q == DONE);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (length == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (last_beat) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst length latch plus issued/sent word counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q      <= '0;
      issued_cnt <= '0;
      sent_cnt   <= '0;
    end else if (start_burst) begin
      len_q      <= length;
      issued_cnt <= '0;
      sent_cnt   <= '0;
    end else if (state_q == DRAIN) begin
      if (rd) begin
        issued_cnt <= issued_cnt + ONE;
      end
      if (pop) begin
        sent_cnt <= sent_cnt + ONE;
      end
    end
  end

  // Track the read whose data arrives next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
    end else begin
      pending <= rd;
    end
  end

  // Two-entry skid buffer: capture arriving Fifo data, shift on pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_cnt <= 2'd0;
      buf0    <= '0;
      buf1    <= '0;
    end else begin
      case ({pending, pop})
        2'b01: begin
          buf0    <= buf1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b10: begin
          if (buf_cnt == 2'd0) begin
            buf0 <= bus.fifo_data;
          end else begin
            buf1 <= bus.fifo_data;
          end
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b11: begin
          // pop and capture together: occupancy unchanged, order kept
          if (buf_cnt == 2'd1) begin
            buf0 <= bus.fifo_data;
          end else begin
            buf0 <= buf1;
            buf1 <= bus.fifo_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Credit gating must keep an arriving word from landing on a full buffer
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    !(pending && !pop && (buf_cnt == 2'd2)));

  // Buffer occupancy stays within its two entries
  a_cnt_range : assert property (@(posedge clk) disable iff (!reset)
    buf_cnt != 2'd3);

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side master for the team's 32-bit Fifo. On `start` it drains exactly `length` words from the FIFO read port and presents them on a valid/ready output stream. The final word is flagged with `m_last`, and `done` pulses once that word has been accepted.
- Sits between a producer-filled Fifo and downstream compute/DMA logic.
- Hides the FIFO's 1-cycle registered read latency behind a 2-entry skid buffer, so throughput is 1 word/cycle.

Parameters:
- DATA_W, 32: data width; must match the Fifo data width.
- LEN_W, 16: width of `length` and of the internal counters; maximum burst is 2^LEN_W-1 words.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  begin a burst; sampled only in IDLE.
- length  input  LEN_W  words to drain; latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  single-cycle pulse at burst end.
- fifo_empty  input  1  Fifo empty flag.
- fifo_data  input  DATA_W  Fifo data_out; valid the cycle after a read is issued.
- fifo_read  output  1  Fifo read strobe.
- m_data  output  DATA_W  stream data.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready; transfer occurs when m_valid && m_ready.
- m_last  output  1  high with the final word of a burst.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE; buffer count, pending flag and both counters clear.
  - busy=0, done=0, fifo_read=0, m_valid=0, m_last=0, m_data=0.
  - Reset mid-burst abandons the burst. Words already popped from the Fifo are discarded, and done is not pulsed.
- States: IDLE, DRAIN, DONE.
- IDLE:
  - start=1 and length>0: latch length; clear issued_cnt and sent_cnt; go to DRAIN next cycle.
  - start=1 and length=0: go to DONE (done pulse next cycle, no reads issued).
  - start while not IDLE: ignored.
- DRAIN, read issue:
  - fifo_read = !fifo_empty && (issued_cnt != length) && (buf_cnt + pending - pop < 2), where pop = m_valid && m_ready in the same cycle.
  - fifo_read is combinational on m_ready; this is permitted.
  - Each issued read increments issued_cnt and sets pending for the next cycle.
  - fifo_read is never asserted while fifo_empty=1 or while in IDLE/DONE.
- DRAIN, capture:
  - In the cycle where pending=1, fifo_data is written into the skid buffer on the closing edge.
  - Buffer is 2 entries, FIFO-ordered; buf_cnt ranges 0..2.
  - The credit rule guarantees no overflow. Simultaneous capture and pop leaves buf_cnt unchanged.
- Output:
  - m_valid = (buf_cnt != 0); m_data = head entry.
  - While m_valid=1 && m_ready=0, m_data and m_last hold stable.
  - m_last = m_valid && (sent_cnt == length-1).
  - Each transfer increments sent_cnt.
- Transfer of the last word (sent_cnt reaches length): go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0; return to IDLE.
  - A start in the DONE cycle is ignored; a new start is accepted from the following IDLE cycle.
- Throughput and latency:
  - With fifo_empty=0 and m_ready=1 continuously: fifo_read is high every cycle from the first DRAIN cycle.
  - First m_valid appears 2 cycles after the first fifo_read (1 cycle Fifo latency + 1 capture). Sustained rate is 1 word/cycle.
- Fifo empty mid-burst: issuing stalls and resumes when fifo_empty=0. Word order is preserved and no word is duplicated or dropped.
- Counters are LEN_W wide; no wrap occurs since counts never exceed length.

Test Plan:
- Full-rate burst: Fifo preloaded with 0x10..0x17, start with length=8, m_ready=1 → eight back-to-back beats 0x10..0x17. m_last is high only on 0x17, and done pulses 1 cycle later.
- Backpressure: length=4, m_ready toggling 1,0,0,1,... → m_data holds stable while m_ready=0. Never more than 2 reads are outstanding or buffered, and words arrive in order.
- Empty stall: Fifo holds 2 words, length=5; 3 more words are written 10 cycles later → fifo_read stays 0 while fifo_empty=1. All 5 words arrive in order and done pulses once.
- Zero length: start with length=0 → no fifo_read, no m_valid; done pulses on the next cycle.
- Ignored start: a second start during busy, and a start in the DONE cycle → no effect on the counters or the current burst.
- Async reset mid-burst: reset=0 asserted between clock edges after 3 of 8 words → outputs go to 0 immediately. After release, a new burst with length=2 drains the next 2 Fifo words correctly.
